data_mem_arb: RTL

DATA_MEM_ARB -- requirements
Module: data_mem_arb

---
 rtl/data_mem_arb_pkg.sv | 14 +
 rtl/data_mem_arb_rr_arb2.sv | 45 ++++
 rtl/data_mem_arb.sv | 104 ++++++++++
 3 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared control definitions for the data-memory arbiter: memory command
// encodings and port identifiers.
package data_mem_arb_pkg;

    typedef enum logic [1:0] {
        MEMNOP = 2'b00,
        MEMWLD = 2'b01,
        MEMWST = 2'b10
    } dm_cmd_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/data_mem_arb_rr_arb2.sv
// Two-requester round-robin arbiter. Grants are combinational from the
// eligible requests; last_grant remembers the most recent winner so that a
// tie goes to the other port.
module rr_arb2
    import data_mem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic last_grant;

    // Pick a winner: a lone requester wins, a tie goes opposite last_grant.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            if (last_grant == PORT1) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
        end else if (req0) begin
            gnt0 = 1'b1;
        end else if (req1) begin
            gnt1 = 1'b1;
        end
    end

    // Remember the winner; idle cycles leave the history untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= PORT1;
        end else if (gnt0) begin
            last_grant <= PORT0;
        end else if (gnt1) begin
            last_grant <= PORT1;
        end
    end

endmodule

// File: rtl/data_mem_arb.sv
// Data-memory arbiter: two request ports share one single-cycle data memory.
// Arbitration is decided from this cycle's requests and the winning access is
// driven to memory, registered, in the following cycle. Load data returns the
// cycle after the load is issued.
module data_mem_arb
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              rvalid,
    output logic              rport,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_ctrl_addr,
    output logic [DATA_W-1:0] data_in,
    output logic [1:0]        dm_ctrl_sig,
    input  logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic    elig0;
    logic    elig1;
    logic    win0;
    logic    win1;
    dm_cmd_e cmd_q;

    // A request held through its own grant cycle must not win again there.
    assign elig0 = p0_req & ~p0_gnt;
    assign elig1 = p1_req & ~p1_gnt;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .reset (reset),
        .req0  (elig0),
        .req1  (elig1),
        .gnt0  (win0),
        .gnt1  (win1)
    );

    // Register the winning access onto the memory command bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0_gnt        <= 1'b0;
            p1_gnt        <= 1'b0;
            mem_ctrl_addr <= '0;
            data_in       <= '0;
            cmd_q         <= MEMNOP;
        end else begin
            p0_gnt <= win0;
            p1_gnt <= win1;
            if (win0) begin
                mem_ctrl_addr <= p0_addr;
                data_in       <= p0_we ? p0_wdata : '0;
                cmd_q         <= p0_we ? MEMWST : MEMWLD;
            end else if (win1) begin
                mem_ctrl_addr <= p1_addr;
                data_in       <= p1_we ? p1_wdata : '0;
                cmd_q         <= p1_we ? MEMWST : MEMWLD;
            end else begin
                mem_ctrl_addr <= '0;
                data_in       <= '0;
                cmd_q         <= MEMNOP;
            end
        end
    end

    // Flag the return cycle of a load and remember which port issued it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid <= 1'b0;
            rport  <= PORT0;
        end else begin
            rvalid <= (cmd_q == MEMWLD);
            rport  <= (cmd_q == MEMWLD) ? p1_gnt : PORT0;
        end
    end

    // Count contended cycles, sticking at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (elig0 && elig1 && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

    // The memory presents read data in the return cycle; mask it otherwise.
    assign rdata       = rvalid ? data_out : '0;
    assign dm_ctrl_sig = cmd_q;

endmodule
